mu_ledger: RTL and testbench
============================

Name: mu_ledger

Overview:
- Multi-channel successor to the single-port MDL accounting unit.
- Accepts MDL cost requests from NUM_CH independent requesters and arbitrates them round-robin. Computes each cost with an iterative ceil-log2 engine, charges it against a programmable μ budget, and keeps per-module cumulative μ.
- Sits between the CPU/partition logic and the μ status/CSR path.

Parameters:
- NUM_CH, 4: number of requester channels (1..8).
- NUM_MODULES, 64: number of tracked module slots.
- ID_W, 6: module_id width; must satisfy 2^ID_W >= NUM_MODULES.
- SIZE_W, 32: module_size width.
- MU_W, 32: width of the accumulator, cost and per-module μ.
- MU_BUDGET, 2^MU_W-1: maximum legal value of total_mu.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_CH  per-channel request, four-phase
- req_module_id  in  NUM_CH*ID_W  flattened per-channel module id
- req_size  in  NUM_CH*SIZE_W  flattened per-channel module size
- req_consistent  in  NUM_CH  per-channel consistency flag
- ack  out  NUM_CH  per-channel acknowledge
- rsp_cost  out  MU_W  cost of the acknowledged request
- rsp_err  out  2  0 ok, 1 invalid module, 2 inconsistent, 3 budget overflow
- total_mu  out  MU_W  global accumulator
- op_count  out  32  committed (charged) operation count
- err_sticky  out  3  bit per error class {overflow, inconsistent, invalid}
- clear_err  in  1  single-cycle pulse; clears err_sticky
- rd_module_id  in  ID_W  query address
- rd_module_mu  out  MU_W  cumulative μ of rd_module_id, 1-cycle registered latency

Behaviour:
- Reset: FSM to IDLE; outputs ack, rsp_cost, rsp_err, total_mu, op_count, err_sticky and rd_module_mu all 0; every per-module μ 0; round-robin pointer 0. Reset mid-operation aborts the transaction; no partial commit.
- FSM states: IDLE, CALC, COMMIT, ACK.
- IDLE:
  - Grant the first asserted req at or after the pointer, searching upward with wrap.
  - Latch that channel's module_id, size and consistent flag; inputs are not resampled after the grant.
  - Go to CALC.
- CALC:
  - For size >= 2: shift (size-1) right one bit per cycle and count until zero. cost = bit-length(size-1) = ceil(log2 size). CALC lasts that many cycles.
  - For size 0 or 1: cost 0, 1 cycle.
  - For inconsistent: cost = all ones, 1 cycle; the size check is skipped.
- COMMIT: 1 cycle. Conditions are checked in priority order:
  - module_id >= NUM_MODULES: err 1, nothing updated.
  - !consistent: err 2, no charge.
  - total_mu + cost > MU_BUDGET, evaluated at MU_W+1 bits: err 3, total_mu unchanged.
  - Otherwise: err 0; total_mu += cost; op_count += 1 (wraps); module_mu[id] += cost, saturating at 2^MU_W-1.
  - Any nonzero err sets the matching err_sticky bit.
- ACK:
  - ack[ch] rises on the edge after COMMIT. rsp_cost and rsp_err are valid and stable while ack is high.
  - ack stays high until req[ch] is sampled low, then drops on that edge.
  - Pointer moves to ch+1 mod NUM_CH; FSM returns to IDLE.
  - At most one ack bit is high at any time.
- Latency: ack rises N+2 edges after the grant edge, where N = CALC cycles.
- A size-0 request commits with cost 0, err 0 and increments op_count.
- Channels that are not granted wait with req held; there is no starvation, since each channel waits at most NUM_CH-1 transactions.
- clear_err coinciding with a new error in COMMIT: the new error bit wins (set).
- rd_module_mu: registered read of module_mu[rd_module_id]; returns 0 for id >= NUM_MODULES. When the read coincides with a COMMIT write to the same id, it returns the pre-update value.

Test Plan:
- Reset, then ch0 requests id 3, size 1000, consistent -> ack after 12 cycles (N=10); rsp_cost 10, err 0; total_mu 10; op_count 1; rd_module_mu(3) = 10.
- ch0..ch3 assert simultaneously, each size 2 -> acks in order 0,1,2,3. Next simultaneous round starts with ch0, since the pointer is back at 0 after ch3. Then a round with only ch1 and ch3 asserted -> ch1 is granted first.
- id 5, size 17, consistent=0 -> rsp_cost all ones, err 2; total_mu unchanged; err_sticky[inconsistent]=1. clear_err pulse -> err_sticky 0.
- MU_BUDGET=20, total_mu 15, size 64 (cost 6) -> err 3, total_mu stays 15. Then size 32 (cost 5) -> err 0, total_mu 20.
- NUM_MODULES=48, id 50, size 8 -> err 1; op_count unchanged; rd_module_mu(50) = 0.
- Assert rst_n low during CALC of a size-2^20 request -> all outputs 0 immediately. After release, ack stays low until req is re-presented.

Source files
------------

// File: rtl/mu_ledger_if.sv
// Requester-side handshake bundle for mu_ledger: per-channel four-phase
// request lanes (flattened) plus the shared response.
interface mu_ledger_if #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = 6,
    parameter int SIZE_W = 32,
    parameter int MU_W   = 32
);
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH*ID_W-1:0]   req_module_id;
    logic [NUM_CH*SIZE_W-1:0] req_size;
    logic [NUM_CH-1:0]        req_consistent;
    logic [NUM_CH-1:0]        ack;
    logic [MU_W-1:0]          rsp_cost;
    logic [1:0]               rsp_err;

    modport master (output req, req_module_id, req_size, req_consistent,
                    input  ack, rsp_cost, rsp_err);
    modport slave  (input  req, req_module_id, req_size, req_consistent,
                    output ack, rsp_cost, rsp_err);
endinterface

// File: rtl/mu_ledger.sv
// Multi-channel MDL cost ledger: round-robin grant, iterative ceil-log2 cost,
// budget-checked commit into a global total and per-module cumulative mu.
module mu_ledger #(
    parameter int              NUM_CH      = 4,
    parameter int              NUM_MODULES = 64,
    parameter int              ID_W        = 6,
    parameter int              SIZE_W      = 32,
    parameter int              MU_W        = 32,
    parameter logic [MU_W-1:0] MU_BUDGET   = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    mu_ledger_if.slave       bus,
    input  logic             clear_err_i,
    input  logic [ID_W-1:0]  rd_module_id_i,
    output logic [MU_W-1:0]  total_mu_o,
    output logic [31:0]      op_count_o,
    output logic [2:0]       err_sticky_o,
    output logic [MU_W-1:0]  rd_module_mu_o
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, COMMIT, ACK} state_e;
    state_e state_q, state_d;

    logic [CH_W-1:0]   ptr_q, ch_q, gnt_ch, hi_ch, lo_ch;
    logic              gnt_vld, hi_vld, req_sel;
    logic [ID_W-1:0]   id_q, sel_id;
    logic [SIZE_W-1:0] shift_q, sel_size;
    logic              cons_q, sel_cons, ack_q;
    logic [MU_W-1:0]   cnt_q, cost_c, total_q, rsp_cost_q, rd_q, rd_d, mu_at_id;
    logic [MU_W:0]     sum_c, mu_sum;
    logic [1:0]        err_c, rsp_err_q;
    logic [31:0]       op_q;
    logic [2:0]        sticky_q, sticky_d;
    logic [MU_W-1:0]   mu_q [NUM_MODULES];

    // Round-robin: lowest requester at/above the pointer, else lowest overall.
    always_comb begin
        gnt_vld = 1'b0;
        hi_vld  = 1'b0;
        hi_ch   = '0;
        lo_ch   = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (bus.req[j]) begin
                gnt_vld = 1'b1;
                lo_ch   = CH_W'(j);
                if (CH_W'(j) >= ptr_q) begin
                    hi_vld = 1'b1;
                    hi_ch  = CH_W'(j);
                end
            end
        end
        gnt_ch = hi_vld ? hi_ch : lo_ch;
    end

    always_comb begin
        sel_id   = '0;
        sel_size = '0;
        sel_cons = 1'b0;
        req_sel  = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (CH_W'(j) == gnt_ch) begin
                sel_id   = bus.req_module_id[j*ID_W +: ID_W];
                sel_size = bus.req_size[j*SIZE_W +: SIZE_W];
                sel_cons = bus.req_consistent[j];
            end
            if (CH_W'(j) == ch_q) req_sel = bus.req[j];
        end
    end

    always_comb begin
        rd_d     = '0;
        mu_at_id = '0;
        for (int i = 0; i < NUM_MODULES; i++) begin
            if (rd_module_id_i == ID_W'(i)) rd_d     = mu_q[i];
            if (id_q == ID_W'(i))           mu_at_id = mu_q[i];
        end
    end

    // Commit arithmetic; the budget test is done one bit wider than MU_W.
    always_comb begin
        cost_c = cons_q ? cnt_q : '1;
        sum_c  = {1'b0, total_q} + {1'b0, cost_c};
        mu_sum = {1'b0, mu_at_id} + {1'b0, cost_c};
        err_c  = 2'd0;
        if (32'(id_q) >= 32'(NUM_MODULES)) err_c = 2'd1;
        else if (!cons_q)                   err_c = 2'd2;
        else if (sum_c > {1'b0, MU_BUDGET}) err_c = 2'd3;
        sticky_d = clear_err_i ? 3'b000 : sticky_q;
        if (state_q == COMMIT && err_c != 2'd0) sticky_d[err_c - 2'd1] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_vld) state_d = CALC;
            CALC:    if (!cons_q || shift_q[SIZE_W-1:1] == '0) state_d = COMMIT;
            COMMIT:  state_d = ACK;
            ACK:     if (ack_q && !req_sel) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ack = '0;
        for (int j = 0; j < NUM_CH; j++)
            if (ack_q && CH_W'(j) == ch_q) bus.ack[j] = 1'b1;
        bus.rsp_cost   = rsp_cost_q;
        bus.rsp_err    = rsp_err_q;
        total_mu_o     = total_q;
        op_count_o     = op_q;
        err_sticky_o   = sticky_q;
        rd_module_mu_o = rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            ch_q       <= '0;
            id_q       <= '0;
            shift_q    <= '0;
            cons_q     <= 1'b0;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            rsp_cost_q <= '0;
            rsp_err_q  <= 2'd0;
            total_q    <= '0;
            op_q       <= '0;
            sticky_q   <= 3'b000;
            rd_q       <= '0;
            for (int i = 0; i < NUM_MODULES; i++) mu_q[i] <= '0;
        end else begin
            rd_q     <= rd_d;
            sticky_q <= sticky_d;
            case (state_q)
                IDLE: if (gnt_vld) begin
                    ch_q    <= gnt_ch;
                    id_q    <= sel_id;
                    cons_q  <= sel_cons;
                    shift_q <= (sel_size > SIZE_W'(1)) ? sel_size - SIZE_W'(1) : '0;
                    cnt_q   <= '0;
                end
                // cost = number of shifts until (size-1) drains to zero
                CALC: if (cons_q && shift_q != '0) begin
                    shift_q <= shift_q >> 1;
                    cnt_q   <= cnt_q + MU_W'(1);
                end
                COMMIT: begin
                    rsp_cost_q <= cost_c;
                    rsp_err_q  <= err_c;
                    if (err_c == 2'd0) begin
                        total_q <= sum_c[MU_W-1:0];
                        op_q    <= op_q + 32'd1;
                        for (int i = 0; i < NUM_MODULES; i++)
                            if (id_q == ID_W'(i))
                                mu_q[i] <= mu_sum[MU_W] ? '1 : mu_sum[MU_W-1:0];
                    end
                end
                ACK: begin
                    if (!ack_q) ack_q <= 1'b1;
                    else if (!req_sel) begin
                        ack_q <= 1'b0;
                        ptr_q <= (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mu_ledger.sv
// Bench for mu_ledger: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized four-phase traffic.
module tb_mu_ledger;
    localparam int          NCH    = 4;
    localparam int          NMOD   = 48;
    localparam int          IDW    = 6;
    localparam int          SW     = 32;
    localparam int          MW     = 32;
    localparam logic [31:0] BUDGET = 32'd20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NCH-1:0] req = '0, cons = '0;
    logic [IDW-1:0] id_a [NCH];
    logic [SW-1:0]  size_a [NCH];
    logic           clear_err = 1'b0;
    logic [IDW-1:0] rd_id = '0;
    logic [MW-1:0]  total_mu, rd_mu;
    logic [31:0]    op_count;
    logic [2:0]     err_sticky;

    int tests = 0;
    int fails = 0;

    mu_ledger_if #(.NUM_CH(NCH), .ID_W(IDW), .SIZE_W(SW), .MU_W(MW)) bus();

    assign bus.req            = req;
    assign bus.req_consistent = cons;
    for (genvar g = 0; g < NCH; g++) begin : g_pack
        assign bus.req_module_id[g*IDW +: IDW] = id_a[g];
        assign bus.req_size[g*SW +: SW]        = size_a[g];
    end

    mu_ledger #(.NUM_CH(NCH), .NUM_MODULES(NMOD), .ID_W(IDW), .SIZE_W(SW),
                .MU_W(MW), .MU_BUDGET(BUDGET)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .clear_err_i(clear_err),
        .rd_module_id_i(rd_id), .total_mu_o(total_mu), .op_count_o(op_count),
        .err_sticky_o(err_sticky), .rd_module_mu_o(rd_mu));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ceil(log2(size)) by searching powers of two
    function automatic logic [31:0] ref_cost(input logic [31:0] size, input logic c);
        int n = 0;
        if (!c) return 32'hFFFF_FFFF;
        while ((64'd1 << n) < {32'd0, size}) n++;
        return 32'(n);
    endfunction

    // ---------------- reference model ----------------
    int           m_phase, m_ch, m_cnt, m_ptr, m_err;
    logic [5:0]   m_id;
    logic [31:0]  m_size, m_cost, m_total, m_op, m_rd;
    logic         m_cons;
    logic [2:0]   m_sticky;
    logic [3:0]   m_ack;
    logic [31:0]  m_mu [64];
    logic [31:0]  m_rsp_cost;
    logic [1:0]   m_rsp_err;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_phase = 0; m_ptr = 0; m_cnt = 0; m_ch = 0;
                m_total = 0; m_op = 0; m_sticky = 0; m_ack = 0; m_rd = 0;
                m_rsp_cost = 0; m_rsp_err = 0;
                for (int i = 0; i < 64; i++) m_mu[i] = 0;
            end else begin
                m_rd = (rd_id < NMOD) ? m_mu[rd_id] : 32'd0;
                if (clear_err) m_sticky = 3'b000;
                case (m_phase)
                    0: if (req != 0) begin
                        for (int k = 0; k < NCH; k++)
                            if (req[(m_ptr + k) % NCH]) begin m_ch = (m_ptr + k) % NCH; break; end
                        m_id = id_a[m_ch]; m_size = size_a[m_ch]; m_cons = cons[m_ch];
                        m_cost = ref_cost(m_size, m_cons);
                        m_cnt = ((!m_cons || m_size < 2) ? 1 : int'(m_cost)) + 2;
                        m_phase = 1;
                    end
                    1: begin
                        m_cnt--;
                        if (m_cnt == 1) begin
                            if (m_id >= NMOD) m_err = 1;
                            else if (!m_cons) m_err = 2;
                            else if ({32'd0, m_total} + {32'd0, m_cost} > {32'd0, BUDGET}) m_err = 3;
                            else begin
                                m_err = 0;
                                m_total = m_total + m_cost;
                                m_op = m_op + 1;
                                m_mu[m_id] = ({32'd0, m_mu[m_id]} + {32'd0, m_cost} > 64'hFFFF_FFFF)
                                             ? 32'hFFFF_FFFF : m_mu[m_id] + m_cost;
                            end
                            if (m_err != 0) m_sticky[m_err-1] = 1'b1;
                            m_rsp_cost = m_cost;
                            m_rsp_err  = 2'(m_err);
                        end
                        if (m_cnt == 0) begin m_ack = 4'(1 << m_ch); m_phase = 2; end
                    end
                    default: if (!req[m_ch]) begin
                        m_ack = 0; m_ptr = (m_ch + 1) % NCH; m_phase = 0;
                    end
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("ack", {60'd0, bus.ack}, {60'd0, m_ack});
                if (m_ack != 0) begin
                    chk("rsp_cost", {32'd0, bus.rsp_cost}, {32'd0, m_rsp_cost});
                    chk("rsp_err", {62'd0, bus.rsp_err}, {62'd0, m_rsp_err});
                end
                if (!(m_phase == 1 && m_cnt == 1)) begin
                    chk("total_mu", {32'd0, total_mu}, {32'd0, m_total});
                    chk("op_count", {32'd0, op_count}, {32'd0, m_op});
                    chk("err_sticky", {61'd0, err_sticky}, {61'd0, m_sticky});
                end
                chk("rd_module_mu", {32'd0, rd_mu}, {32'd0, m_rd});
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_one(input int c, input logic [5:0] id, input logic [31:0] sz,
                          input logic cn, output int lat, output logic [31:0] cost,
                          output logic [1:0] err);
        int cyc = 0;
        bit got = 0;
        lat = -1; cost = 0; err = 0;
        id_a[c] = id; size_a[c] = sz; cons[c] = cn; req[c] = 1'b1;
        while (!got && cyc < 300) begin
            @(negedge clk); cyc++;
            if (bus.ack[c]) got = 1;
        end
        if (got) begin lat = cyc - 1; cost = bus.rsp_cost; err = bus.rsp_err; end
        else begin tests++; fails++; $display("FAIL ack_timeout: ch%0d no ack in 300 cycles", c); end
        req[c] = 1'b0;
        cyc = 0;
        while (bus.ack[c] && cyc < 10) begin @(negedge clk); cyc++; end
        chk("ack_release", {63'd0, bus.ack[c]}, 64'd0);
    endtask

    task automatic do_round(input logic [3:0] mask, output logic [15:0] ord);
        int cyc = 0;
        ord = '0;
        for (int c = 0; c < NCH; c++)
            if (mask[c]) begin id_a[c] = 6'(c); size_a[c] = 2; cons[c] = 1'b1; end
        req = mask;
        while ((req != 0 || bus.ack != 0) && cyc < 400) begin
            @(negedge clk); cyc++;
            for (int c = 0; c < NCH; c++)
                if (bus.ack[c] && req[c]) begin ord = {ord[11:0], 4'(c)}; req[c] = 1'b0; end
        end
        if (cyc >= 400) begin tests++; fails++; $display("FAIL round_timeout: mask %0h", mask); end
    endtask

    task automatic pulse_reset();
        req = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    int          lat, st [NCH], wt [NCH], to [NCH], done [NCH];
    logic [31:0] cost;
    logic [1:0]  err;
    logic [15:0] ord;

    initial begin
        for (int c = 0; c < NCH; c++) begin id_a[c] = 0; size_a[c] = 0; end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_total", {32'd0, total_mu}, 64'd0);
        chk("reset_op", {32'd0, op_count}, 64'd0);
        chk("reset_sticky", {61'd0, err_sticky}, 64'd0);
        chk("reset_ack", {60'd0, bus.ack}, 64'd0);

        do_one(0, 6'd3, 32'd1000, 1'b1, lat, cost, err);
        chk("lat_1000", 64'(lat), 64'd12);
        chk("cost_1000", {32'd0, cost}, 64'd10);
        chk("err_1000", {62'd0, err}, 64'd0);
        chk("total_1000", {32'd0, total_mu}, 64'd10);
        chk("op_1000", {32'd0, op_count}, 64'd1);
        rd_id = 6'd3;
        repeat (2) @(negedge clk);
        chk("rd_mu3", {32'd0, rd_mu}, 64'd10);

        pulse_reset();
        do_round(4'b1111, ord); chk("rr_round1", {48'd0, ord}, 64'h0123);
        do_round(4'b1111, ord); chk("rr_round2", {48'd0, ord}, 64'h0123);
        do_round(4'b1010, ord); chk("rr_ch1_ch3", {48'd0, ord}, 64'h0013);
        chk("rr_total", {32'd0, total_mu}, 64'd10);
        chk("rr_op", {32'd0, op_count}, 64'd10);

        do_one(2, 6'd5, 32'd17, 1'b0, lat, cost, err);
        chk("incons_cost", {32'd0, cost}, 64'hFFFF_FFFF);
        chk("incons_err", {62'd0, err}, 64'd2);
        chk("incons_total", {32'd0, total_mu}, 64'd10);
        chk("incons_sticky", {61'd0, err_sticky}, 64'b010);
        clear_err = 1'b1; @(negedge clk); clear_err = 1'b0; @(negedge clk);
        chk("clear_sticky", {61'd0, err_sticky}, 64'd0);

        pulse_reset();
        do_one(1, 6'd7, 32'd32768, 1'b1, lat, cost, err);
        chk("bud_total15", {32'd0, total_mu}, 64'd15);
        do_one(1, 6'd7, 32'd64, 1'b1, lat, cost, err);
        chk("ovf_cost", {32'd0, cost}, 64'd6);
        chk("ovf_err", {62'd0, err}, 64'd3);
        chk("ovf_total", {32'd0, total_mu}, 64'd15);
        do_one(1, 6'd7, 32'd32, 1'b1, lat, cost, err);
        chk("fit_err", {62'd0, err}, 64'd0);
        chk("fit_total", {32'd0, total_mu}, 64'd20);

        do_one(3, 6'd50, 32'd8, 1'b1, lat, cost, err);
        chk("inv_err", {62'd0, err}, 64'd1);
        chk("inv_op", {32'd0, op_count}, 64'd2);
        chk("inv_sticky", {61'd0, err_sticky}, 64'b101);
        rd_id = 6'd50; repeat (2) @(negedge clk);
        chk("rd_mu50", {32'd0, rd_mu}, 64'd0);
        rd_id = 6'd7; repeat (2) @(negedge clk);
        chk("rd_mu7", {32'd0, rd_mu}, 64'd20);

        id_a[0] = 6'd1; size_a[0] = 32'h0010_0000; cons[0] = 1'b1; req[0] = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0; req = '0;
        #1;
        chk("arst_total", {32'd0, total_mu}, 64'd0);
        chk("arst_op", {32'd0, op_count}, 64'd0);
        chk("arst_sticky", {61'd0, err_sticky}, 64'd0);
        chk("arst_ack", {60'd0, bus.ack}, 64'd0);
        chk("arst_rsp", {30'd0, bus.rsp_err, bus.rsp_cost}, 64'd0);
        chk("arst_rd", {32'd0, rd_mu}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_ack", {60'd0, bus.ack}, 64'd0);
        do_one(0, 6'd1, 32'd4, 1'b1, lat, cost, err);
        chk("post_rst_cost", {32'd0, cost}, 64'd2);
        chk("post_rst_total", {32'd0, total_mu}, 64'd2);

        // randomized four-phase traffic on all channels
        for (int b = 0; b < 5; b++) begin
            int cyc = 0;
            bit busy = 1;
            for (int c = 0; c < NCH; c++) begin st[c] = 0; wt[c] = c; to[c] = 0; done[c] = 0; end
            while (busy && cyc < 8000) begin
                @(negedge clk); cyc++;
                rd_id = 6'($urandom_range(0, 63));
                clear_err = !clear_err && ($urandom_range(0, 15) == 0);
                busy = 0;
                for (int c = 0; c < NCH; c++) begin
                    case (st[c])
                        0: if (done[c] < 10) begin
                            if (wt[c] > 0) wt[c]--;
                            else begin
                                int k = $urandom_range(0, 7);
                                id_a[c] = 6'($urandom_range(0, 63));
                                cons[c] = ($urandom_range(0, 7) != 0);
                                size_a[c] = (k == 0) ? 32'd0 : (k == 1) ? 32'd1 :
                                            (k < 6) ? 32'($urandom_range(2, 16)) :
                                            (k == 6) ? 32'($urandom_range(17, 4096)) : 32'($urandom);
                                req[c] = 1'b1; to[c] = 0; st[c] = 1;
                            end
                        end
                        1: if (bus.ack[c]) begin req[c] = 1'b0; st[c] = 2; end
                           else if (++to[c] > 400) begin
                               tests++; fails++;
                               $display("FAIL rand_timeout: ch%0d batch %0d", c, b);
                               req[c] = 1'b0; st[c] = 2;
                           end
                        default: if (!bus.ack[c]) begin
                            st[c] = 0; done[c]++; wt[c] = $urandom_range(0, 3);
                        end
                    endcase
                    if (st[c] != 0 || done[c] < 10) busy = 1;
                end
            end
            if (busy) begin tests++; fails++; $display("FAIL batch_timeout: batch %0d", b); end
            clear_err = 1'b0;
            pulse_reset();
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
